sub_bytes_iter: RTL and testbench

Iterative AES SubBytes / InvSubBytes stage that sits directly upstream of the ShiftRows stage in the round datapath. It accepts a 128-bit state over a valid/ready handshake and substitutes `BYTES_PER_CYCLE` bytes per clock through shared S-box lanes. It presents the substituted state, in unchanged byte positions, to the ShiftRows input. It trades latency for area: 16 S-boxes at full width, 4 at the default.

---
 rtl/aes_pkg.sv | 57 +++++
 rtl/aes_sbox.sv | 14 +
 rtl/sub_bytes_iter.sv | 114 +++++++++++
 tb/tb_sub_bytes_iter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, iterative-stage FSM states, FIPS-197 S-box tables.
// Latency: none (constants and a pure combinational lookup function).
// Backpressure: not applicable.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Forward or inverse substitution of one byte.
  function automatic logic [7:0] sbox(input logic [7:0] b, input logic inv);
    return inv ? SBOX_INV[b] : SBOX_FWD[b];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// One S-box lane: substitutes a single byte, forward or inverse.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data,
  input  logic       inv,
  output logic [7:0] subst
);

  assign subst = sbox(data, inv);

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative SubBytes/InvSubBytes: BYTES_PER_CYCLE shared S-box lanes walk the state MSB chunk first.
// Latency: N = 16/BYTES_PER_CYCLE cycles in BUSY; out_valid rises after edge T+N for a block accepted at edge T.
// Backpressure: the finished block is held in DONE until out_ready; a new block is taken only as the old one leaves.
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  input  logic                   in_inv,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data
);

  localparam int N   = 16 / BYTES_PER_CYCLE;
  localparam int CHW = 8 * BYTES_PER_CYCLE;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [AES_BLOCK_W-1:0] st, st_nxt;
  logic                   inv_q, inv_nxt;
  logic [CHW-1:0]         chunk, chunk_sub;

  // Select chunk cnt from the working register; chunk 0 is the MSB end.
  always_comb begin
    chunk = '0;
    for (int c = 0; c < N; c++) begin
      if (cnt == CW'(c)) chunk = st[AES_BLOCK_W-1-c*CHW -: CHW];
    end
  end

  for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
    aes_sbox u_sbox (
      .data  (chunk[CHW-1-8*j -: 8]),
      .inv   (inv_q),
      .subst (chunk_sub[CHW-1-8*j -: 8])
    );
  end

  // Next-state, chunk write-back and handshake outputs.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    st_nxt    = st;
    inv_nxt   = inv_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_nxt    = in_data;
          inv_nxt   = in_inv;
          cnt_nxt   = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // Substituted bytes go back to the slots they came from.
        for (int c = 0; c < N; c++) begin
          if (cnt == CW'(c)) st_nxt[AES_BLOCK_W-1-c*CHW -: CHW] = chunk_sub;
        end
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            st_nxt    = in_data;
            inv_nxt   = in_inv;
            cnt_nxt   = '0;
            state_nxt = BUSY;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // No handshake may complete while reset is being applied.
    if (rst) in_ready = 1'b0;
  end

  // State, counter, working register and mode flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      st    <= '0;
      inv_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      st    <= st_nxt;
      inv_q <= inv_nxt;
    end
  end

  assign out_data = st;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: GF(2^8)-derived S-box model, per-cycle scoreboard, directed and random traffic.
// Latency: checks N+1 cycles from acceptance to out_valid for 4, 1 and 16 lanes.
// Backpressure: exercises held DONE, back-to-back handoff, reset mid-block.
module tb_sub_bytes_iter;

  localparam int N = 4;
  localparam logic [127:0] VEC     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] VEC_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, in_inv, out_valid, out_ready;
  logic [127:0] in_data, out_data;
  logic         s1_in_valid, s1_in_ready, s1_in_inv, s1_out_valid, s1_out_ready;
  logic [127:0] s1_in_data, s1_out_data;
  logic         s16_in_valid, s16_in_ready, s16_in_inv, s16_out_valid, s16_out_ready;
  logic [127:0] s16_in_data, s16_out_data;

  sub_bytes_iter #(.BYTES_PER_CYCLE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));
  sub_bytes_iter #(.BYTES_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_data(s1_in_data),
    .in_inv(s1_in_inv), .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_data(s1_out_data));
  sub_bytes_iter #(.BYTES_PER_CYCLE(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(s16_in_valid), .in_ready(s16_in_ready), .in_data(s16_in_data),
    .in_inv(s16_in_inv), .out_valid(s16_out_valid), .out_ready(s16_out_ready), .out_data(s16_out_data));

  int total = 0;
  int bad = 0;
  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // S-box from first principles: multiplicative inverse then affine map.
  task automatic build_tables();
    logic [7:0] binv;
    logic [7:0] s;
    for (int a = 0; a < 256; a++) begin
      binv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gf_mul(8'(a), 8'(b)) == 8'h01) binv = 8'(b);
      end
      s = binv ^ rotl(binv, 1) ^ rotl(binv, 2) ^ rotl(binv, 3) ^ rotl(binv, 4) ^ 8'h63;
      fwd_tab[a] = s;
      inv_tab[s] = 8'(a);
    end
  endtask

  function automatic logic [127:0] subst(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = inv ? inv_tab[d[8*k +: 8]] : fwd_tab[d[8*k +: 8]];
    return r;
  endfunction

  // Scoreboard for the default-width DUT: a block becomes visible N+1 cycles after acceptance.
  bit chk_en = 1'b0;
  bit pending = 1'b0;
  int age = 0;
  logic [127:0] exp_q [$];

  always @(negedge clk) begin
    bit exp_vld;
    bit exp_rdy;
    if (chk_en) begin
      if (pending) age++;
      exp_vld = pending && (age >= N + 1);
      exp_rdy = !rst && (!pending || (exp_vld && out_ready));
      check("sb_out_valid", 128'(out_valid), 128'(exp_vld));
      check("sb_in_ready", 128'(in_ready), 128'(exp_rdy));
      if (exp_vld && exp_q.size() > 0) check("sb_out_data", out_data, exp_q[0]);
      if (rst) begin
        pending = 1'b0;
        exp_q.delete();
      end else begin
        if (exp_vld && out_ready) begin
          void'(exp_q.pop_front());
          pending = 1'b0;
        end
        if (in_valid && exp_rdy) begin
          exp_q.push_back(subst(in_data, in_inv));
          pending = 1'b1;
          age = 0;
        end
      end
    end
  end

  task automatic push_blk(input logic [127:0] d, input logic inv);
    int k;
    in_data  = d;
    in_inv   = inv;
    in_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 200);
    if (!in_ready) check("push_timeout", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [127:0] d, output int lat);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 100);
    if (!out_valid) check("out_timeout", 128'(out_valid), 128'(1));
    d = out_data;
    lat = k;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] d, d1, d16;
    logic [127:0] blk [3];
    logic         binv [3];
    int lat, lat1, lat16, nout, cyc, idx;
    int t [3];
    bit acc;

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b0;
    s1_in_valid = 1'b0; s1_in_data = '0; s1_in_inv = 1'b0; s1_out_ready = 1'b0;
    s16_in_valid = 1'b0; s16_in_data = '0; s16_in_inv = 1'b0; s16_out_ready = 1'b0;

    build_tables();
    check("model_S53", 128'(fwd_tab[8'h53]), 128'(8'hed));
    check("model_invS63", 128'(inv_tab[8'h63]), 128'(8'h00));
    check("model_vec", subst(VEC, 1'b0), VEC_OUT);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data", out_data, 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 128'(in_ready), 128'(1));
    chk_en = 1'b1;

    // Forward vector
    out_ready = 1'b1;
    push_blk(VEC, 1'b0);
    wait_out(d, lat);
    check("fwd_data", d, VEC_OUT);
    check_int("fwd_latency", lat, 5);

    // Inverse round trip
    push_blk(VEC_OUT, 1'b1);
    wait_out(d, lat);
    check("inv_data", d, VEC);

    // Backpressure
    out_ready = 1'b0;
    push_blk(VEC, 1'b0);
    wait_out(d, lat);
    check_int("bp_latency", lat, 5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 128'(out_valid), 128'(1));
      check("bp_data", out_data, VEC_OUT);
      check("bp_in_ready", 128'(in_ready), 128'(0));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_after_valid", 128'(out_valid), 128'(0));
    check("bp_after_ready", 128'(in_ready), 128'(1));

    // Back-to-back, three blocks
    for (int i = 0; i < 3; i++) begin
      blk[i]  = {$urandom, $urandom, $urandom, $urandom};
      binv[i] = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_data = blk[0]; in_inv = binv[0];
    idx = 0; nout = 0; cyc = 0;
    while (nout < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      acc = in_valid && in_ready;
      if (out_valid) begin
        check("b2b_data", out_data, subst(blk[nout], binv[nout]));
        t[nout] = cyc;
        nout++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 3) begin
          in_data = blk[idx];
          in_inv  = binv[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check_int("b2b_count", nout, 3);
    if (nout == 3) begin
      check_int("b2b_gap1", t[1] - t[0], 5);
      check_int("b2b_gap2", t[2] - t[1], 5);
    end

    // Reset while BUSY with cnt = 2
    push_blk(VEC, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("rb_valid", 128'(out_valid), 128'(0));
      check("rb_data", out_data, 128'(0));
      check("rb_in_ready", 128'(in_ready), 128'(1));
    end
    push_blk(VEC_OUT, 1'b1);
    wait_out(d, lat);
    check("rb_next_data", d, VEC);

    // Random traffic with occasional reset pulses
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 63) == 0);
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_inv   = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check_int("rand_drained", exp_q.size(), 0);

    // Lane-count sweep: same vector through 1 and 16 lanes
    s1_out_ready = 1'b1; s16_out_ready = 1'b1;
    s1_in_data = VEC; s16_in_data = VEC;
    s1_in_valid = 1'b1; s16_in_valid = 1'b1;
    @(negedge clk);
    check("s1_in_ready", 128'(s1_in_ready), 128'(1));
    check("s16_in_ready", 128'(s16_in_ready), 128'(1));
    @(posedge clk);
    #1;
    s1_in_valid = 1'b0; s16_in_valid = 1'b0;
    lat1 = 0; lat16 = 0; d1 = '0; d16 = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (s1_out_valid && lat1 == 0) begin
        lat1 = k;
        d1 = s1_out_data;
      end
      if (s16_out_valid && lat16 == 0) begin
        lat16 = k;
        d16 = s16_out_data;
      end
    end
    check_int("s1_latency", lat1, 17);
    check_int("s16_latency", lat16, 2);
    check("s1_data", d1, VEC_OUT);
    check("s16_data", d16, VEC_OUT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
